// File: rtl/spi_slave_axis_igress_fifo.sv
// spi_slave_axis_igress_fifo
// Ingress bridge from the SPI slave shifter into the clk domain. The slow
// s_axis_tvalid level is synchronized and each rising edge captures one
// beat into a first-word-fall-through FIFO. The FIFO drains through an
// AXIS master and flags dropped beats with a sticky overflow bit.
module spi_slave_axis_igress_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEST_WIDTH  = 8,
    parameter int ID_WIDTH    = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       resn,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [DEST_WIDTH-1:0]      s_axis_tdest,
    input  logic [ID_WIDTH-1:0]        s_axis_tid,
    input  logic                       s_axis_tlast,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [DEST_WIDTH-1:0]      m_axis_tdest,
    output logic [ID_WIDTH-1:0]        m_axis_tid,
    output logic                       m_axis_tlast,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       overflow_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef struct packed {
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   vs;
    logic                   vs_d;
    logic                   armed;
    logic                   push_req;
    logic                   push_q;
    beat_t                  beat_q;
    beat_t                  mem [DEPTH];
    beat_t                  head;
    logic [AW:0]            wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic                   full, empty, full_nxt;
    logic                   pop, push_ok, ovf_set;

    assign vs       = sync[SYNC_STAGES-1];
    assign push_req = armed & vs & ~vs_d;

    // Synchronizer chain plus a parallel fill marker. The marker tells when
    // vs reflects a post-reset sample, so a valid held high through reset
    // release never looks like a fresh low level and cannot arm the capture.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            sync  <= '0;
            fill  <= '0;
            vs_d  <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], s_axis_tvalid};
            fill  <= {fill[SYNC_STAGES-2:0], 1'b1};
            vs_d  <= vs;
            armed <= armed | (fill[SYNC_STAGES-1] & ~vs);
        end
    end

    // Capture stage: sample the (stable) source payload on the valid edge.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            push_q <= 1'b0;
            beat_q <= '0;
        end else begin
            push_q <= push_req;
            if (push_req)
                beat_q <= {s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tdata};
        end
    end

    // FIFO status and next-pointer computation.
    always_comb begin
        empty      = (wr_ptr == rd_ptr);
        full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        pop        = ~empty & m_axis_tready;
        push_ok    = push_q & (~full | pop);
        ovf_set    = push_q & full & ~pop;
        wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push_ok};
        rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
        full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                     (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
    end

    // Pointers, registered ready and the sticky overflow flag.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            s_axis_tready <= 1'b1;
            overflow      <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            s_axis_tready <= ~full_nxt;
            if (ovf_set)
                overflow <= 1'b1;
            else if (overflow_clear)
                overflow <= 1'b0;
        end
    end

    // Storage array; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= beat_q;
        end
    end

    // First-word-fall-through head: outputs depend only on registered state.
    always_comb begin
        head          = mem[rd_ptr[AW-1:0]];
        m_axis_tvalid = ~empty;
        m_axis_tdata  = head.data;
        m_axis_tdest  = head.dest;
        m_axis_tid    = head.id;
        m_axis_tlast  = head.last;
        level         = LW'(wr_ptr - rd_ptr);
    end

endmodule

// File: tb/tb_spi_slave_axis_igress_fifo.sv
// Directed bench for spi_slave_axis_igress_fifo with default parameters
// (8-bit fields, DEPTH=4, SYNC_STAGES=2).
module tb_spi_slave_axis_igress_fifo;

    logic       clk = 1'b0;
    logic       resn;
    logic [7:0] s_tdata, s_tdest, s_tid;
    logic       s_tvalid, s_tlast, s_tready;
    logic [7:0] m_tdata, m_tdest, m_tid;
    logic       m_tvalid, m_tready, m_tlast;
    logic [2:0] level;
    logic       overflow, overflow_clear;

    int checks = 0;
    int errors = 0;

    logic       mon_en = 1'b0;
    logic [7:0] got [$];

    always #5 clk = ~clk;

    spi_slave_axis_igress_fifo dut (
        .clk            (clk),
        .resn           (resn),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .s_axis_tdest   (s_tdest),
        .s_axis_tid     (s_tid),
        .s_axis_tlast   (s_tlast),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tdest   (m_tdest),
        .m_axis_tid     (m_tid),
        .m_axis_tlast   (m_tlast),
        .level          (level),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    // Record every beat that will be accepted at the coming rising edge.
    always @(negedge clk)
        if (mon_en && m_tvalid && m_tready)
            got.push_back(m_tdata);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic [7:0] dst,
                             input logic [7:0] id, input logic last);
        s_tdata  = d;
        s_tdest  = dst;
        s_tid    = id;
        s_tlast  = last;
        s_tvalid = 1'b1;
        repeat (4) step();
        s_tvalid = 1'b0;
        repeat (4) step();
    endtask

    task automatic drain4(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_vld"}, m_tvalid, 1'b1);
            check({tag, "_data"}, m_tdata, e[i]);
            step();
        end
        m_tready = 1'b0;
        check({tag, "_empty"}, m_tvalid, 1'b0);
        check({tag, "_level0"}, level, 0);
    endtask

    initial begin
        resn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tdest = '0; s_tid = '0;
        s_tlast = 1'b0; m_tready = 1'b0; overflow_clear = 1'b0;
        repeat (3) step();

        // Reset values
        check("rst_mvalid", m_tvalid, 1'b0);
        check("rst_mdata", m_tdata, 8'h00);
        check("rst_mlast", m_tlast, 1'b0);
        check("rst_sready", s_tready, 1'b1);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 1'b0);
        resn = 1'b1;
        repeat (6) step();

        // Single beat: valid seen at the head four edges after the rise
        m_tready = 1'b1;
        s_tdata = 8'hA5; s_tdest = 8'h03; s_tid = 8'h07; s_tlast = 1'b1;
        s_tvalid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("lat_early_vld", m_tvalid, 1'b0);
        end
        step();
        check("lat_vld", m_tvalid, 1'b1);
        check("lat_data", m_tdata, 8'hA5);
        check("lat_dest", m_tdest, 8'h03);
        check("lat_id", m_tid, 8'h07);
        check("lat_last", m_tlast, 1'b1);
        step();
        check("lat_one_cycle", m_tvalid, 1'b0);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        repeat (4) step();
        check("lat_no_repeat", m_tvalid, 1'b0);

        // Backpressure: fill four beats then drain on consecutive cycles
        for (int i = 1; i <= 4; i++) send_beat(8'(i), 8'h0, 8'h0, 1'b0);
        check("bp_level", level, 4);
        check("bp_sready", s_tready, 1'b0);
        drain4("bp", 8'h01, 8'h02, 8'h03, 8'h04);
        check("bp_sready_back", s_tready, 1'b1);

        // Overflow: fifth beat dropped, sticky until cleared
        for (int i = 0; i < 4; i++) send_beat(8'h21 + 8'(i), 8'h0, 8'h0, 1'b0);
        send_beat(8'h55, 8'h0, 8'h0, 1'b0);
        check("ovf_set", overflow, 1'b1);
        check("ovf_level", level, 4);
        step();
        check("ovf_sticky", overflow, 1'b1);
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        drain4("ovf", 8'h21, 8'h22, 8'h23, 8'h24);

        // Full with simultaneous pop: push accepted, level unchanged
        for (int i = 0; i < 4; i++) send_beat(8'h31 + 8'(i), 8'h0, 8'h0, 1'b0);
        check("fp_level_pre", level, 4);
        s_tdata = 8'h66;
        s_tvalid = 1'b1;
        repeat (3) step();
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        check("fp_level", level, 4);
        check("fp_ovf", overflow, 1'b0);
        check("fp_head", m_tdata, 8'h32);
        s_tvalid = 1'b0;
        repeat (4) step();
        drain4("fp", 8'h32, 8'h33, 8'h34, 8'h66);

        // Reset with valid held high across release
        send_beat(8'h41, 8'h0, 8'h0, 1'b0);
        send_beat(8'h42, 8'h0, 8'h0, 1'b0);
        check("rv_level_pre", level, 2);
        s_tdata = 8'h77;
        s_tvalid = 1'b1;
        step();
        resn = 1'b0;
        #1;
        check("rv_async_level", level, 0);
        check("rv_async_vld", m_tvalid, 1'b0);
        repeat (3) step();
        resn = 1'b1;
        repeat (10) step();
        check("rv_no_beat_level", level, 0);
        check("rv_no_beat_vld", m_tvalid, 1'b0);
        s_tvalid = 1'b0;
        repeat (6) step();
        send_beat(8'h9C, 8'h0, 8'h0, 1'b0);
        check("rv_level", level, 1);
        check("rv_data", m_tdata, 8'h9C);
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        check("rv_drained", m_tvalid, 1'b0);

        // Pointer wrap: 10 beats with ready toggling every cycle
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) send_beat(8'h10 + 8'(i), 8'h0, 8'h0, 1'b0);
            end
            begin
                for (int c = 0; c < 90; c++) begin
                    step();
                    m_tready = ~m_tready;
                end
            end
        join
        step();
        mon_en = 1'b0;
        m_tready = 1'b0;
        check("wrap_count", got.size(), 10);
        for (int i = 0; i < 10; i++)
            check("wrap_data", (i < got.size()) ? got[i] : 8'hXX, 8'h10 + 8'(i));
        check("wrap_ovf", overflow, 1'b0);
        check("wrap_level", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
